// File: rtl/kmp_pkg.sv
// Shared definitions for the KMP failure-table builder and the searcher that reads the table.
// The FSM state codes are visible on actual_state, so their values are fixed.
package kmp_pkg;

  localparam int KMP_ADDR_W  = 5;
  localparam int KMP_ENTRY_W = KMP_ADDR_W + 1;
  localparam logic [KMP_ENTRY_W-1:0] KMP_NEG1 = '1;

  // A table entry is one bit wider than an address so that it can hold -1.
  function automatic int kmp_entry_w(input int addr_w);
    return addr_w + 1;
  endfunction

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT   = 4'd1,
    S_CHECK  = 4'd2,
    S_RD_PC  = 4'd3,
    S_CMP    = 4'd4,
    S_WR_EQ  = 4'd5,
    S_WR_NE  = 4'd6,
    S_FB_LD  = 4'd7,
    S_FB_CMP = 4'd8,
    S_ADV    = 4'd9,
    S_FINAL  = 4'd10,
    S_DONE   = 4'd11
  } kmp_state_t;

endpackage

// File: rtl/kmp_table_builder_if.sv
// Control, pattern-RAM and table-RAM signals of the KMP table builder.
// master is the builder's view of the bundle; slave is the view of the sequencer and the RAMs.
interface kmp_table_builder_if #(
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 5
);
  logic                     start;
  logic [ADDR_W-1:0]        len;
  logic [ADDR_W-1:0]        pat_addr;
  logic [CHAR_W-1:0]        pat_data;
  logic [ADDR_W-1:0]        tbl_raddr;
  logic signed [ADDR_W:0]   tbl_rdata;
  logic                     tbl_we;
  logic [ADDR_W-1:0]        tbl_waddr;
  logic signed [ADDR_W:0]   tbl_wdata;
  logic                     busy;
  logic                     done;
  logic [3:0]               actual_state;

  modport master (
    input  start, len, pat_data, tbl_rdata,
    output pat_addr, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, busy, done, actual_state
  );

  modport slave (
    output start, len, pat_data, tbl_rdata,
    input  pat_addr, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, busy, done, actual_state
  );
endinterface

// File: rtl/kmp_table_builder.sv
// Writes the KMP failure table T[0..len] for the pattern held in the pattern RAM.
// Both RAMs have a one-cycle read latency, so each lookup is issued one state ahead of its use.
module kmp_table_builder
  import kmp_pkg::*;
#(
  parameter int CHAR_W = 8,
  parameter int ADDR_W = KMP_ADDR_W
) (
  input logic clk,
  input logic rst,
  kmp_table_builder_if.master bus
);

  localparam int EW = kmp_entry_w(ADDR_W);

  kmp_state_t               state_q, state_d;
  logic [ADDR_W-1:0]        pos_q;
  logic [ADDR_W-1:0]        len_q;
  logic signed [EW-1:0]     cnd_q;
  logic [CHAR_W-1:0]        p_pos_q;

  logic signed [EW-1:0]     rdata;
  logic [ADDR_W-1:0]        cnd_addr;
  logic [ADDR_W-1:0]        rdata_addr;
  logic                     pat_eq;

  assign rdata      = bus.tbl_rdata;
  assign cnd_addr   = cnd_q[ADDR_W-1:0];
  assign rdata_addr = rdata[ADDR_W-1:0];
  assign pat_eq     = (bus.pat_data == p_pos_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      cnd_q   <= '0;
      p_pos_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE:  if (bus.start) len_q <= bus.len;
        S_INIT: begin
          pos_q <= ADDR_W'(1);
          cnd_q <= '0;
        end
        S_RD_PC: p_pos_q <= bus.pat_data;
        S_FB_LD: cnd_q   <= rdata;
        S_ADV: begin
          pos_q <= pos_q + ADDR_W'(1);
          cnd_q <= cnd_q + EW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.pat_addr  = pos_q;
    bus.tbl_raddr = cnd_addr;
    bus.tbl_we    = 1'b0;
    bus.tbl_waddr = pos_q;
    bus.tbl_wdata = cnd_q;
    bus.busy      = (state_q != S_IDLE);
    bus.done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = (bus.len == '0) ? S_DONE : S_INIT;
      end
      S_INIT: begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = '0;
        bus.tbl_wdata = '1;
        state_d       = S_CHECK;
      end
      S_CHECK: begin
        bus.pat_addr = pos_q;
        state_d      = (pos_q >= len_q) ? S_FINAL : S_RD_PC;
      end
      S_RD_PC: begin
        bus.pat_addr = cnd_addr;
        state_d      = S_CMP;
      end
      S_CMP: begin
        bus.tbl_raddr = cnd_addr;
        state_d       = pat_eq ? S_WR_EQ : S_WR_NE;
      end
      S_WR_EQ: begin
        bus.tbl_we    = 1'b1;
        bus.tbl_wdata = rdata;
        state_d       = S_ADV;
      end
      // cnd < pos here, so the fallback read never hits the entry being written.
      S_WR_NE: begin
        bus.tbl_we    = 1'b1;
        bus.tbl_wdata = cnd_q;
        bus.tbl_raddr = cnd_addr;
        state_d       = S_FB_LD;
      end
      S_FB_LD: begin
        if (rdata[EW-1]) begin
          state_d = S_ADV;
        end else begin
          bus.pat_addr = rdata_addr;
          state_d      = S_FB_CMP;
        end
      end
      S_FB_CMP: begin
        bus.tbl_raddr = cnd_addr;
        state_d       = pat_eq ? S_ADV : S_FB_LD;
      end
      S_ADV:   state_d = S_CHECK;
      S_FINAL: begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = len_q;
        state_d       = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.actual_state = state_q;

endmodule
